// File: rtl/regpair_file_p.sv
// Register file of NPAIR byte-addressable pairs with a 3-state inc/dec engine.
// Define REGPAIR_ZERO_EN to add the registered zero_out flag.
module regpair_file_p #(
    parameter  int DW    = 8,
    parameter  int NPAIR = 6,
    localparam int AW    = 2 * DW,
    localparam int SW    = (NPAIR > 1) ? $clog2(NPAIR) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_sel,
    input  logic          wr_hi,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [SW-1:0] rd_sel,
    input  logic          rd_hi,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [SW-1:0] op_sel,
    input  logic          op_dec,
    input  logic          op_two,
    input  logic          op_wb,
    output logic [AW-1:0] addr_out,
    output logic [AW-1:0] result,
    output logic          carry_out,
    output logic          op_done
`ifdef REGPAIR_ZERO_EN
    ,
    output logic          zero_out
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    localparam logic [SW:0] NPAIR_L = (SW + 1)'(NPAIR);

    logic [AW-1:0] pairs [NPAIR];
    logic [1:0]    state;
    logic [SW-1:0] cap_sel;
    logic          cap_ok;
    logic          cap_dec;
    logic          cap_two;
    logic          cap_wb;
    logic [AW:0]   step;
    logic [AW:0]   calc;
    logic          wr_ok;
    logic          rd_ok;
    logic          op_ok;
    logic          wb_fire;

    assign wr_ok    = ({1'b0, wr_sel} < NPAIR_L);
    assign rd_ok    = ({1'b0, rd_sel} < NPAIR_L);
    assign op_ok    = ({1'b0, op_sel} < NPAIR_L);
    assign op_ready = (state == IDLE);
    assign wb_fire  = (state == WB) && cap_wb && cap_ok;

    // Extra MSB of the AW+1 bit sum/difference is the carry or borrow.
    always_comb begin
        step = {{(AW-1){1'b0}}, cap_two, ~cap_two};
        calc = '0;
        if (cap_dec)
            calc = {1'b0, addr_out} - step;
        else
            calc = {1'b0, addr_out} + step;
    end

    // NOTE: the pair storage is a small flop array, so it is cleared on reset like
    // any other state; a RAM macro could not be reset this way.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPAIR; i++)
                pairs[i] <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            // Non-blocking reads of pairs see the pre-write value on a collision.
            if (rd_en)
                rd_data <= !rd_ok ? '0 :
                           rd_hi  ? pairs[rd_sel][AW-1:DW] : pairs[rd_sel][DW-1:0];
            if (wr_en && wr_ok) begin
                if (wr_hi)
                    pairs[wr_sel][AW-1:DW] <= wr_data;
                else
                    pairs[wr_sel][DW-1:0] <= wr_data;
            end
            // Last assignment wins, so writeback overrides a same-pair byte write.
            if (wb_fire)
                pairs[cap_sel] <= result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_out  <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            op_done   <= 1'b0;
            cap_sel   <= '0;
            cap_ok    <= 1'b0;
            cap_dec   <= 1'b0;
            cap_two   <= 1'b0;
            cap_wb    <= 1'b0;
`ifdef REGPAIR_ZERO_EN
            zero_out  <= 1'b0;
`endif
        end else begin
            op_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        state    <= CALC;
                        addr_out <= op_ok ? pairs[op_sel] : '0;
                        cap_sel  <= op_sel;
                        cap_ok   <= op_ok;
                        cap_dec  <= op_dec;
                        cap_two  <= op_two;
                        cap_wb   <= op_wb;
                    end
                end
                CALC: begin
                    state     <= WB;
                    result    <= calc[AW-1:0];
                    carry_out <= calc[AW];
                    op_done   <= 1'b1;
`ifdef REGPAIR_ZERO_EN
                    zero_out  <= (calc[AW-1:0] == '0);
`endif
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regpair_file_p.sv
// Directed self-checking bench for regpair_file_p (default parameters, DW=8, NPAIR=6).
// Honours REGPAIR_ZERO_EN when the design is built with it.
module tb_regpair_file_p;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [SW-1:0] wr_sel;
    logic          wr_hi;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [SW-1:0] rd_sel;
    logic          rd_hi;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          op_valid;
    logic          op_ready;
    logic [SW-1:0] op_sel;
    logic          op_dec;
    logic          op_two;
    logic          op_wb;
    logic [AW-1:0] addr_out;
    logic [AW-1:0] result;
    logic          carry_out;
    logic          op_done;
`ifdef REGPAIR_ZERO_EN
    logic          zero_out;
`endif

    int n_checks = 0;
    int n_errors = 0;

    regpair_file_p #(.DW(DW), .NPAIR(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_hi     (wr_hi),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_sel    (rd_sel),
        .rd_hi     (rd_hi),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_sel    (op_sel),
        .op_dec    (op_dec),
        .op_two    (op_two),
        .op_wb     (op_wb),
        .addr_out  (addr_out),
        .result    (result),
        .carry_out (carry_out),
        .op_done   (op_done)
`ifdef REGPAIR_ZERO_EN
        ,
        .zero_out  (zero_out)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next edge; outputs are sampled 1ns later, inputs changed there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [SW-1:0] sel, input logic hi, input logic [DW-1:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_hi = hi; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_byte(input string tag, input logic [SW-1:0] sel, input logic hi,
                             input logic [DW-1:0] exp);
        rd_en = 1'b1; rd_sel = sel; rd_hi = hi;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, rd_data}, {24'd0, exp});
    endtask

    // Runs one op through IDLE->CALC->WB->IDLE; optional byte write lands on the WB->IDLE edge.
    task automatic run_op(input string tag, input logic [SW-1:0] sel, input logic dec,
                          input logic two, input logic wb, input logic [AW-1:0] exp_addr,
                          input logic [AW-1:0] exp_res, input logic exp_carry,
                          input logic do_wr, input logic [SW-1:0] wsel, input logic whi,
                          input logic [DW-1:0] wdata);
        check({tag, "_ready_idle"}, {31'd0, op_ready}, 32'd1);
        op_valid = 1'b1; op_sel = sel; op_dec = dec; op_two = two; op_wb = wb;
        tick();
        op_valid = 1'b0;
        check({tag, "_ready_calc"}, {31'd0, op_ready}, 32'd0);
        check({tag, "_addr"}, {16'd0, addr_out}, {16'd0, exp_addr});
        check({tag, "_done_calc"}, {31'd0, op_done}, 32'd0);
        tick();
        check({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
        check({tag, "_carry"}, {31'd0, carry_out}, {31'd0, exp_carry});
        check({tag, "_done_wb"}, {31'd0, op_done}, 32'd1);
`ifdef REGPAIR_ZERO_EN
        check({tag, "_zero"}, {31'd0, zero_out}, {31'd0, (exp_res == 16'h0000)});
`endif
        if (do_wr) begin
            wr_en = 1'b1; wr_sel = wsel; wr_hi = whi; wr_data = wdata;
        end
        tick();
        wr_en = 1'b0;
        check({tag, "_done_after"}, {31'd0, op_done}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, op_ready}, 32'd1);
        check({tag, "_result_hold"}, {16'd0, result}, {16'd0, exp_res});
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_sel = '0; wr_hi = 1'b0; wr_data = '0;
        rd_en = 1'b0; rd_sel = '0; rd_hi = 1'b0;
        op_valid = 1'b0; op_sel = '0; op_dec = 1'b0; op_two = 1'b0; op_wb = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check("rst_op_ready", {31'd0, op_ready}, 32'd1);
        check("rst_op_done", {31'd0, op_done}, 32'd0);
        check("rst_addr", {16'd0, addr_out}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_carry", {31'd0, carry_out}, 32'd0);

        // Byte write and readback, one cycle latency.
        write_byte(3'd1, 1'b1, 8'h12);
        write_byte(3'd1, 1'b0, 8'h34);
        read_byte("p1_hi", 3'd1, 1'b1, 8'h12);
        read_byte("p1_lo", 3'd1, 1'b0, 8'h34);
        tick();
        check("rd_valid_idle", {31'd0, rd_valid}, 32'd0);
        check("rd_data_hold", {24'd0, rd_data}, 32'h34);

        // Read/write collision returns the old byte; next read sees the new one.
        wr_en = 1'b1; wr_sel = 3'd1; wr_hi = 1'b1; wr_data = 8'h56;
        rd_en = 1'b1; rd_sel = 3'd1; rd_hi = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("coll_data", {24'd0, rd_data}, 32'h12);
        read_byte("coll_after", 3'd1, 1'b1, 8'h56);
        read_byte("p1_lo_kept", 3'd1, 1'b0, 8'h34);

        // Out-of-range index: read returns 0, write is dropped.
        write_byte(3'd6, 1'b0, 8'hEE);
        read_byte("rd_oob", 3'd7, 1'b0, 8'h00);
        read_byte("rd_sel6", 3'd6, 1'b0, 8'h00);

        // Pair 2 = 00FF, inc by 1 with writeback.
        write_byte(3'd2, 1'b1, 8'h00);
        write_byte(3'd2, 1'b0, 8'hFF);
        run_op("inc1", 3'd2, 1'b0, 1'b0, 1'b1, 16'h00FF, 16'h0100, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        read_byte("p2_hi", 3'd2, 1'b1, 8'h01);
        read_byte("p2_lo", 3'd2, 1'b0, 8'h00);

        // Pair 3 = FFFF, inc by 2 without writeback wraps to 0001.
        write_byte(3'd3, 1'b1, 8'hFF);
        write_byte(3'd3, 1'b0, 8'hFF);
        run_op("inc2wrap", 3'd3, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00);
        check("hold_addr", {16'd0, addr_out}, 32'hFFFF);
        check("hold_carry", {31'd0, carry_out}, 32'd1);
        read_byte("p3_nowb_hi", 3'd3, 1'b1, 8'hFF);
        read_byte("p3_nowb_lo", 3'd3, 1'b0, 8'hFF);

        // Pair 3 = 0001, dec by 2 borrows to FFFF, written back.
        write_byte(3'd3, 1'b1, 8'h00);
        write_byte(3'd3, 1'b0, 8'h01);
        run_op("dec2wrap", 3'd3, 1'b1, 1'b1, 1'b1, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00);
        read_byte("p3_wb_hi", 3'd3, 1'b1, 8'hFF);
        read_byte("p3_wb_lo", 3'd3, 1'b0, 8'hFF);

        // Pair 5 = 0001, dec by 1 reaches zero without borrow.
        write_byte(3'd5, 1'b0, 8'h01);
        run_op("dec1zero", 3'd5, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);

        // Plain increment of pair 1 (5634).
        run_op("inc1p1", 3'd1, 1'b0, 1'b0, 1'b1, 16'h5634, 16'h5635, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        read_byte("p1_inc_lo", 3'd1, 1'b0, 8'h35);

        // Out-of-range op select: addr 0, result 1, op_done still pulses.
        run_op("op_oob", 3'd7, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);

        // Writeback beats a same-pair byte write at the WB->IDLE edge.
        run_op("wb_win", 3'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 3'd0, 1'b0, 8'hAA);
        read_byte("p0_win_hi", 3'd0, 1'b1, 8'h00);
        read_byte("p0_win_lo", 3'd0, 1'b0, 8'h01);

        // A byte write to a different pair at the same edge still lands.
        run_op("wb_other", 3'd0, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1, 3'd4, 1'b1, 8'h77);
        read_byte("p0_other_lo", 3'd0, 1'b0, 8'h02);
        read_byte("p4_hi", 3'd4, 1'b1, 8'h77);

        // Reset during CALC aborts the op and clears everything.
        op_valid = 1'b1; op_sel = 3'd0; op_dec = 1'b0; op_two = 1'b1; op_wb = 1'b1;
        tick();
        op_valid = 1'b0;
        check("abort_in_calc", {31'd0, op_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", {31'd0, op_ready}, 32'd1);
        check("abort_done0", {31'd0, op_done}, 32'd0);
        check("abort_addr", {16'd0, addr_out}, 32'd0);
        check("abort_result", {16'd0, result}, 32'd0);
        tick();
        check("abort_done1", {31'd0, op_done}, 32'd0);
        read_byte("abort_p0_lo", 3'd0, 1'b0, 8'h00);
        read_byte("abort_p1_hi", 3'd1, 1'b1, 8'h00);
        read_byte("abort_p4_hi", 3'd4, 1'b1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regpair_file_p.md
REGPAIR_FILE_P -- requirements
Module: regpair_file_p

Interface
REQ-001 The block SHALL take parameter DW, default 8, as the byte width; each pair is AW=2*DW bits wide.
REQ-002 The block SHALL take parameter NPAIR, default 6, as the number of register pairs; SW=$clog2(NPAIR).
REQ-003 The block SHALL provide port clk  input  1  clock; all state updates on posedge.
REQ-004 The block SHALL provide port rst  input  1  reset rst, synchronous, active-high.
REQ-005 The block SHALL provide port wr_en  input  1  byte write strobe.
REQ-006 The block SHALL provide port wr_sel  input  SW  pair index for byte write.
REQ-007 The block SHALL provide port wr_hi  input  1  1=high byte, 0=low byte (write).
REQ-008 The block SHALL provide port wr_data  input  DW  byte write data.
REQ-009 The block SHALL provide port rd_en  input  1  byte read request.
REQ-010 The block SHALL provide ports rd_sel  input  SW and rd_hi  input  1  read pair index and byte select.
REQ-011 The block SHALL provide ports rd_data  output  DW and rd_valid  output  1  registered read result and its qualifier.
REQ-012 The block SHALL provide ports op_valid  input  1 and op_ready  output  1  inc/dec request handshake.
REQ-013 The block SHALL provide ports op_sel  input  SW, op_dec  input  1 (1=decrement), op_two  input  1 (step 2, else 1), op_wb  input  1 (write result back).
REQ-014 The block SHALL provide ports addr_out  output  AW, result  output  AW, carry_out  output  1, op_done  output  1.

Function
REQ-015 A byte write SHALL update only the selected byte of pair wr_sel at the posedge where wr_en=1; wr_sel>=NPAIR SHALL be ignored.
REQ-016 A read with rd_en=1 at edge T SHALL present the selected byte on rd_data with rd_valid=1 during cycle T+1; rd_valid=0 otherwise; rd_data holds its last value.
REQ-017 A read and a write to the same byte at the same edge SHALL return the pre-write value; rd_sel>=NPAIR SHALL return 0 with rd_valid=1.
REQ-018 The op FSM SHALL have states IDLE, CALC, WB; op_ready=1 only in IDLE.
REQ-019 IDLE->CALC at an edge with op_valid&&op_ready; that edge SHALL latch pair[op_sel] into addr_out and capture op_dec/op_two/op_wb/op_sel.
REQ-020 CALC->WB unconditionally; that edge SHALL register result = addr_out +/- (op_two?2:1) modulo 2^AW and carry_out = carry (inc) or borrow (dec) out of bit AW-1.
REQ-021 op_done SHALL be 1 for exactly the single cycle spent in WB; WB->IDLE unconditionally; throughput one op per 3 cycles.
REQ-022 At the WB->IDLE edge, if the captured op_wb=1, result SHALL be written to the captured pair; if a byte write targets the same pair at that edge, the writeback SHALL win for both bytes.
REQ-023 Wrap-around: 16'hFFFF+1 SHALL give 16'h0000 carry 1; 16'h0001-2 SHALL give 16'hFFFF carry 1 (DW=8).
REQ-024 op_sel>=NPAIR SHALL latch addr_out=0 and suppress writeback; op_done still pulses.
REQ-025 addr_out, result, carry_out SHALL hold until the next accepted op.

Reset
REQ-026 rst=1 at a posedge SHALL clear all pairs, addr_out, result, rd_data to 0, and carry_out, op_done, rd_valid to 0, and force IDLE.
REQ-027 rst asserted mid-operation SHALL abort the op with no writeback and no op_done pulse; rst SHALL take priority over all writes.

Configuration
REQ-028 With macro REGPAIR_ZERO_EN defined, the block SHALL add output zero_out (1 bit), registered with result, =1 iff the result is all zeros, reset 0.
REQ-029 Without REGPAIR_ZERO_EN, zero_out SHALL not exist and behaviour SHALL be otherwise identical.

Verification
REQ-030 Reset, write pair 1 hi=8'h12 lo=8'h34, read both -> rd_data 8'h12 then 8'h34, each one cycle after rd_en.
REQ-031 Pair 2=16'h00FF, op inc step1 wb=1 -> addr_out 16'h00FF in CALC, result 16'h0100, carry 0, op_done one cycle, pair 2 reads 16'h0100.
REQ-032 Pair 3=16'hFFFF, inc step2 wb=0 -> result 16'h0001, carry 1, pair 3 unchanged; then pair 3=16'h0001, dec step2 -> 16'hFFFF, carry 1.
REQ-033 Op on pair 0 with byte write lo=8'hAA to pair 0 at WB->IDLE edge -> pair 0 equals result; write to pair 4 same edge succeeds.
REQ-034 rst asserted in CALC -> no op_done, pair unchanged at 0, op_ready=1 the cycle after reset.
REQ-035 With REGPAIR_ZERO_EN, pair=16'h0001 dec step1 -> result 16'h0000, zero_out 1, carry 0.
